in_pcm_sched: RTL
=================

# in_pcm_sched

Frame scheduler that time-multiplexes one IN_PCM input-conversion/difference datapath across all channels of the multi-channel ADPCM encoder. On each 8 kHz frame strobe it walks channels 0..NUM_CH-1 in order. For each channel it:
- reads the companded sample S and signal estimate SE from channel memory,
- presents them with the channel's law select to IN_PCM,
- writes the 16-bit difference D back to a per-channel result memory.

It sits between the channel sample/state RAMs and the shared IN_PCM instance.

## Interface
Parameters:
- NUM_CH, 32, number of channels per frame (≥2)
- CH_W, 5, channel index width, ≥ clog2(NUM_CH)
- DP_LAT, 1, cycles IN_PCM inputs are held before D is sampled (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- frame_sync  in  1  one-cycle frame start strobe
- law_cfg  in  NUM_CH  per-channel law select (bit n → channel n); sampled at LOAD
- ovr_clr  in  1  clears overrun flag
- rd_en  out  1  channel memory read strobe
- rd_addr  out  CH_W  channel memory read address
- rd_data  in  23  {S[22:15], SE[14:0]}; valid the cycle after rd_en
- pcm_s  out  8  to IN_PCM S
- pcm_se  out  15  to IN_PCM SE
- pcm_law  out  1  to IN_PCM LAW
- pcm_d  in  16  from IN_PCM D (combinational from pcm_* registers)
- wr_en  out  1  result write strobe
- wr_addr  out  CH_W  result address
- wr_data  out  16  difference D
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on last channel's write-back
- overrun  out  1  sticky: frame_sync arrived while busy

## Operation
FSM states: IDLE, RD, LOAD, EXEC, WB.
- IDLE: frame_sync → ch=0, go to RD.
- RD: rd_en=1, rd_addr=ch → LOAD.
- LOAD:
  - register pcm_s=rd_data[22:15], pcm_se=rd_data[14:0], pcm_law=law_cfg[ch]
  - load exec counter with DP_LAT-1 → EXEC
- EXEC: hold pcm_*; counter==0 → WB, else decrement.
- WB:
  - wr_en=1, wr_addr=ch, wr_data=pcm_d (combinational pass-through, sampled by memory this edge)
  - ch<NUM_CH-1 → ch+1, RD
  - ch==NUM_CH-1 → done=1:
    - frame_sync also high this cycle → ch=0, RD (back-to-back frame, no overrun)
    - otherwise → IDLE
- pcm_* registers hold their last values in IDLE/RD and change only in LOAD.
- Channel counter never wraps mid-frame. Terminal compare is ch==NUM_CH-1.

Overrun:
- frame_sync in RD, LOAD, EXEC, or non-final WB is ignored (frame not restarted) and sets overrun.
- ovr_clr clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Per channel: 3+DP_LAT cycles. Frame: NUM_CH·(3+DP_LAT) cycles, 128 at defaults.
- frame_sync at edge k (IDLE) → rd_en high cycle k+1, first wr_en cycle k+4 (DP_LAT=1), done in cycle k+128.
- rd_en, wr_en, and done are each exactly one cycle wide per channel/frame.
- Reset (any state, including mid-frame):
  - state=IDLE, ch=0
  - rd_en=wr_en=busy=done=overrun=0
  - rd_addr=wr_addr=0, wr_data=0, pcm_s=0, pcm_se=0, pcm_law=0
  - No partial write-back after reset. The next frame starts from channel 0.

## Structure
- Shared package mcac_pkg holds:
  - state enum (IDLE, RD, LOAD, EXEC, WB)
  - width constants: S_W=8, SE_W=15, D_W=16, RD_W=23
- Single module, no sub-module. FSM, channel counter, exec counter, and overrun flag are inline. IN_PCM is instantiated by the parent, not inside this block.

## Test plan
- Reset then single frame_sync, NUM_CH=4, DP_LAT=1, memory S=8'h80+n, SE=15'h0010·n, law_cfg=4'b0101:
  - wr_addr sequence 0,1,2,3 with IN_PCM-golden D
  - pcm_law 1,0,1,0
  - done at cycle 16; busy low at cycle 17
- DP_LAT=3: per-channel period 6 cycles; pcm_* stable across all 3 EXEC cycles; wr_data matches golden.
- frame_sync asserted in final WB cycle: no IDLE cycle, rd_addr=0 next cycle, overrun stays 0.
- frame_sync in LOAD of channel 1: frame continues unchanged to channel 3, overrun=1. ovr_clr pulse → 0. Simultaneous set+clear → 1.
- Reset asserted in EXEC of channel 2:
  - next cycle all outputs at reset values, no wr_en for channel 2
  - subsequent frame_sync restarts at rd_addr=0
- Full 32-channel default run against file-driven vectors (both laws): 0 mismatches, done once per frame.

Source files
------------

// File: rtl/mcac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcac_pkg
// Description : Shared types and widths for the multi-channel ADPCM encoder
//               datapath scheduler (frame FSM states, sample/estimate widths).
// Revision    : 1.0 - initial release
// ============================================================================
package mcac_pkg;

    // Frame scheduler states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LOAD = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    // Companded sample, signal estimate, difference and memory word widths
    localparam int S_W  = 8;
    localparam int SE_W = 15;
    localparam int D_W  = 16;
    localparam int RD_W = 23;

endpackage
`default_nettype wire

// File: rtl/in_pcm_sched.sv
`default_nettype none
// ============================================================================
// Module      : in_pcm_sched
// Description : Per-frame scheduler that walks all channels in order, feeding
//               each channel's S/SE/law to the shared IN_PCM datapath and
//               writing the resulting difference D to the result memory.
// Revision    : 1.0 - initial release
// ============================================================================
module in_pcm_sched
    import mcac_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int CH_W   = 5,
    parameter int DP_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_sync,
    input  logic [NUM_CH-1:0] law_cfg,
    input  logic              ovr_clr,
    output logic              rd_en,
    output logic [CH_W-1:0]   rd_addr,
    input  logic [RD_W-1:0]   rd_data,
    output logic [S_W-1:0]    pcm_s,
    output logic [SE_W-1:0]   pcm_se,
    output logic              pcm_law,
    input  logic [D_W-1:0]    pcm_d,
    output logic              wr_en,
    output logic [CH_W-1:0]   wr_addr,
    output logic [D_W-1:0]    wr_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int                  c_EXEC_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CH_W-1:0]     c_LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [c_EXEC_W-1:0] c_EXEC_INIT = c_EXEC_W'(DP_LAT - 1);

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [c_EXEC_W-1:0] r_exec_cnt;
    logic                r_rd_en;
    logic [CH_W-1:0]     r_rd_addr;
    logic [S_W-1:0]      r_pcm_s;
    logic [SE_W-1:0]     r_pcm_se;
    logic                r_pcm_law;
    logic                r_wr_en;
    logic [CH_W-1:0]     r_wr_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;

    logic                w_last_ch;
    logic                w_final_wb;
    logic                w_ovr_set;

    // A frame strobe is only accepted in IDLE or on the final write-back;
    // anywhere else in the frame it is dropped and flagged as an overrun.
    assign w_last_ch  = (r_ch == c_LAST_CH);
    assign w_final_wb = (r_state == WB) && w_last_ch;
    assign w_ovr_set  = frame_sync && (r_state != IDLE) && !w_final_wb;

    // Frame FSM with channel counter, exec counter, IN_PCM operand registers
    // and all strobes registered alongside the state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_exec_cnt <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_pcm_s    <= '0;
            r_pcm_se   <= '0;
            r_pcm_law  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            // Set has priority so a clear cannot hide a simultaneous overrun
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (frame_sync) begin
                        r_ch      <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RD;
                    end
                end
                RD: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_pcm_s    <= rd_data[RD_W-1:SE_W];
                    r_pcm_se   <= rd_data[SE_W-1:0];
                    r_pcm_law  <= law_cfg[r_ch];
                    r_exec_cnt <= c_EXEC_INIT;
                    r_state    <= EXEC;
                end
                EXEC: begin
                    if (r_exec_cnt == '0) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ch;
                        r_done    <= w_last_ch;
                        r_state   <= WB;
                    end else begin
                        r_exec_cnt <= r_exec_cnt - 1'b1;
                    end
                end
                WB: begin
                    if (!w_last_ch) begin
                        r_ch      <= r_ch + 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_ch + 1'b1;
                        r_state   <= RD;
                    end else if (frame_sync) begin
                        // Back-to-back frame: restart without an IDLE cycle
                        r_ch      <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_state   <= RD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign pcm_s   = r_pcm_s;
    assign pcm_se  = r_pcm_se;
    assign pcm_law = r_pcm_law;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    // D passes straight through during write-back; zero otherwise
    assign wr_data = r_wr_en ? pcm_d : '0;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule
`default_nettype wire
